// File: rtl/result_forward_pipe.sv
// result_forward_pipe: MEM/WB result pipeline with operand-forwarding taps.
// Non-load results pass from EX through MEM to WB and can be forwarded from
// either stage. A load stops in MEM and issues a level memory request. The
// returned data then goes to WB, and the loaded value is forwarded only from WB.
// Optional feature macro: RESULT_FORWARD_PIPE_TIMEOUT_EN. When it is defined,
// a load with no response after 255 wait cycles completes with zero data and
// pulses Mem_Timeout.
module result_forward_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Valid_EX,
  input  logic        Write_Enable_EX,
  input  logic [4:0]  rd_EX,
  input  logic [31:0] Alu_Out_EX,
  input  logic        Is_Load_EX,
  input  logic        Freeze_In,
  output logic        Mem_Req,
  output logic [31:0] Mem_Addr,
  input  logic        Mem_Rsp_Valid,
  input  logic [31:0] Mem_Rdata,
  output logic        Write_Enable_MEM,
  output logic [4:0]  rd_MEM,
  output logic [31:0] Alu_Out_MEM,
  output logic        Write_Enable_WB,
  output logic [4:0]  rd_WB,
  output logic [31:0] Loaded_Data_WB,
  output logic        Stall_EX,
  output logic        Mem_Timeout
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t      state;
  state_t      next_state;

  logic        mem_valid;
  logic        mem_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_is_load;

  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        hold_valid;
  logic [31:0] hold_data;

  logic        mem_load;
  logic        rsp_avail;
  logic        timeout_hit;
  logic        advance;
  logic        load_done;
  logic [31:0] load_data;

`ifdef RESULT_FORWARD_PIPE_TIMEOUT_EN
  logic [7:0]  tmo_count;
`endif

  // Decode the pipeline controls, the next FSM state and all the visible outputs
  always_comb begin
    mem_load    = mem_valid && mem_is_load;
    rsp_avail   = Mem_Rsp_Valid || hold_valid;
    timeout_hit = 1'b0;
    Mem_Timeout = 1'b0;
`ifdef RESULT_FORWARD_PIPE_TIMEOUT_EN
    timeout_hit = (state == WAIT_MEM) && !Freeze_In && !rsp_avail && (tmo_count == 8'hFF);
    Mem_Timeout = timeout_hit;
`endif
    advance   = !Freeze_In && (state == IDLE) && !mem_load;
    load_done = !Freeze_In && (state == WAIT_MEM) && (rsp_avail || timeout_hit);
    // A response held back by a freeze takes priority. A timeout completes with zero data.
    load_data = 32'h0;
    if (hold_valid) begin
      load_data = hold_data;
    end else if (Mem_Rsp_Valid) begin
      load_data = Mem_Rdata;
    end

    next_state = state;
    if (!Freeze_In) begin
      case (state)
        IDLE:     if (mem_load)  next_state = WAIT_MEM;
        WAIT_MEM: if (load_done) next_state = IDLE;
        default:  next_state = IDLE;
      endcase
    end

    Mem_Req  = (state == WAIT_MEM);
    Mem_Addr = (state == WAIT_MEM) ? mem_data : 32'h0;

    // EX may move forward in the cycle when the load completes, because MEM frees up on that edge.
    Stall_EX = Freeze_In
            || ((state == IDLE) && mem_load)
            || ((state == WAIT_MEM) && !load_done);

    Write_Enable_MEM = mem_valid && mem_we && !mem_is_load && (mem_rd != 5'd0);
    rd_MEM           = mem_rd;
    Alu_Out_MEM      = mem_data;

    Write_Enable_WB = wb_valid && wb_we && (wb_rd != 5'd0);
    rd_WB           = wb_rd;
    Loaded_Data_WB  = wb_data;
  end

  // Load-handshake FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // MEM and WB stage registers: advance, complete a load, or insert a WB bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid   <= 1'b0;
      mem_we      <= 1'b0;
      mem_rd      <= 5'd0;
      mem_data    <= 32'h0;
      mem_is_load <= 1'b0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 32'h0;
    end else if (advance) begin
      mem_valid   <= Valid_EX;
      mem_we      <= Write_Enable_EX;
      mem_rd      <= rd_EX;
      mem_data    <= Alu_Out_EX;
      mem_is_load <= Is_Load_EX;
      wb_valid    <= mem_valid;
      wb_we       <= mem_we;
      wb_rd       <= mem_rd;
      wb_data     <= mem_data;
    end else if (load_done) begin
      mem_valid   <= Valid_EX;
      mem_we      <= Write_Enable_EX;
      mem_rd      <= rd_EX;
      mem_data    <= Alu_Out_EX;
      mem_is_load <= Is_Load_EX;
      wb_valid    <= mem_valid;
      wb_we       <= mem_we;
      wb_rd       <= mem_rd;
      wb_data     <= load_data;
    end else if (!Freeze_In) begin
      wb_valid    <= 1'b0;
    end
  end

  // One-entry buffer that keeps a response which arrives while the pipe is frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= 32'h0;
    end else if ((state == WAIT_MEM) && Freeze_In && Mem_Rsp_Valid && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_data  <= Mem_Rdata;
    end else if (load_done) begin
      hold_valid <= 1'b0;
    end
  end

`ifdef RESULT_FORWARD_PIPE_TIMEOUT_EN
  // Count unanswered wait cycles; the count holds while frozen and clears whenever no load is waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_count <= 8'd0;
    end else if ((state != WAIT_MEM) || load_done) begin
      tmo_count <= 8'd0;
    end else if (!Freeze_In) begin
      tmo_count <= tmo_count + 8'd1;
    end
  end
`endif

endmodule
